id_exe_stage: RTL

- ID/EXE pipeline register for the 5-stage RV32I core.
- Captures forwarded operands (rs1F/rs2F from the forwarding unit), immediate, PC and control fields at the ID/EXE boundary, and presents them to EXE.
- Owns load-use hazard detection: raises a stall to the PC and IF/ID registers and inserts one bubble into EXE.
- Also handles branch flush, downstream hold, and a saturating hazard counter for performance monitoring.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/hazard_detect.sv | 29 ++
 rtl/id_exe_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline types and widths
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REGW   = 5;
   localparam int ALUOPW = 4;

   typedef enum logic [ALUOPW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_t;

   typedef struct packed {
      logic              Wreg;
      logic              MemRead;
      logic              MemWrite;
      logic [ALUOPW-1:0] ALUop;
   } ctrl_t;

   // An all-zero control word is a bubble: no writes, no memory access, ALU_ADD.
   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard and stall generation
module hazard_detect #(
   parameter int REGW = 5
) (
   input  logic            valid_exe,
   input  logic            memread_exe,
   input  logic [REGW-1:0] rd_exe,
   input  logic            valid_id,
   input  logic            use_rs1,
   input  logic            use_rs2,
   input  logic [REGW-1:0] addr1,
   input  logic [REGW-1:0] addr2,
   input  logic            flush,
   input  logic            hold,
   output logic            lu,
   output logic            stall
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = use_rs1 && (addr1 == rd_exe);
   assign rs2_hit = use_rs2 && (addr2 == rd_exe);

   // x0 never carries a dependence, so a load into rd 0 is ignored.
   assign lu    = valid_exe && memread_exe && (rd_exe != '0) && valid_id && (rs1_hit || rs2_hit);
   assign stall = lu && !flush && !hold;

endmodule

// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - ID/EXE pipeline register with load-use bubble insertion
module id_exe_stage #(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int REGW   = riscv_pkg::REGW,
   parameter int ALUOPW = riscv_pkg::ALUOPW,
   parameter int CNTW   = 16
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [XLEN-1:0]   rs1F,
   input  logic [XLEN-1:0]   rs2F,
   input  logic [REGW-1:0]   addr1,
   input  logic [REGW-1:0]   addr2,
   input  logic              use_rs1,
   input  logic              use_rs2,
   input  logic [REGW-1:0]   rd_ID,
   input  logic [XLEN-1:0]   imm_ID,
   input  logic [XLEN-1:0]   pc_ID,
   input  logic              valid_ID,
   input  logic              Wreg_ID,
   input  logic              MemRead_ID,
   input  logic              MemWrite_ID,
   input  logic [ALUOPW-1:0] ALUop_ID,
   input  logic              flush,
   input  logic              hold,
   output logic [XLEN-1:0]   rs1_EXE,
   output logic [XLEN-1:0]   rs2_EXE,
   output logic [XLEN-1:0]   imm_EXE,
   output logic [XLEN-1:0]   pc_EXE,
   output logic [REGW-1:0]   rd_EXE,
   output logic              Wreg_EXE,
   output logic              MemRead_EXE,
   output logic              MemWrite_EXE,
   output logic              valid_EXE,
   output logic [ALUOPW-1:0] ALUop_EXE,
   output logic              stall,
   output logic [CNTW-1:0]   hazard_count
);

   import riscv_pkg::*;

   ctrl_t           ctrl_q;
   ctrl_t           ctrl_d;
   logic            valid_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] pc_q;
   logic [REGW-1:0] rd_q;
   logic [CNTW-1:0] count_q;
   logic            lu;

   hazard_detect #(.REGW(REGW)) u_hazard_detect (
      .valid_exe   (valid_q),
      .memread_exe (ctrl_q.MemRead),
      .rd_exe      (rd_q),
      .valid_id    (valid_ID),
      .use_rs1     (use_rs1),
      .use_rs2     (use_rs2),
      .addr1       (addr1),
      .addr2       (addr2),
      .flush       (flush),
      .hold        (hold),
      .lu          (lu),
      .stall       (stall)
   );

   always_comb begin
      ctrl_d = BUBBLE_CTRL;
      if (valid_ID) begin
         ctrl_d.Wreg     = Wreg_ID;
         ctrl_d.MemRead  = MemRead_ID;
         ctrl_d.MemWrite = MemWrite_ID;
         ctrl_d.ALUop    = ALUop_ID;
      end
   end

   // hold freezes everything; flush outranks the load-use bubble.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         ctrl_q  <= BUBBLE_CTRL;
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (!hold) begin
         if (flush || lu) begin
            ctrl_q  <= BUBBLE_CTRL;
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
         end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_ID;
            rs1_q   <= rs1F;
            rs2_q   <= rs2F;
            imm_q   <= imm_ID;
            pc_q    <= pc_ID;
            rd_q    <= rd_ID;
         end
         if (stall && (count_q != '1)) begin
            count_q <= count_q + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign rs1_EXE      = rs1_q;
   assign rs2_EXE      = rs2_q;
   assign imm_EXE      = imm_q;
   assign pc_EXE       = pc_q;
   assign rd_EXE       = rd_q;
   assign Wreg_EXE     = ctrl_q.Wreg;
   assign MemRead_EXE  = ctrl_q.MemRead;
   assign MemWrite_EXE = ctrl_q.MemWrite;
   assign ALUop_EXE    = ctrl_q.ALUop;
   assign valid_EXE    = valid_q;
   assign hazard_count = count_q;

endmodule
